beat_grid_gen: RTL and testbench

Parametrised successor to the fixed eighth-note rate driver. Generates a musical timing grid from the 50 MHz clock: a sub-beat tick, a beat pulse, a bar pulse, and position counters within the bar. The tick period is programmable at run time. Start, pause and stop control lets the note-drop FSM, register shifter and chorus sender run in lockstep.

---
 rtl/beat_grid_gen.sv | 208 ++++++++++++++++++++
 tb/tb_beat_grid_gen.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/beat_grid_gen.sv
// beat_grid_gen: programmable sub-beat tick / beat / bar timing grid with start, pause and stop control.
// Optional feature macro TEMPO_SWING_EN: alternating long/short tick intervals around the programmed period.
module beat_grid_gen #(
  parameter int CNT_W          = 25,
  parameter int DEFAULT_PERIOD = 13157895,
  parameter int SUBDIV         = 2,
  parameter int BEATS_PER_BAR  = 4,
  parameter int BAR_W          = 8,
  localparam int SUB_W         = (SUBDIV > 1) ? $clog2(SUBDIV) : 1,
  localparam int BEAT_W        = (BEATS_PER_BAR > 1) ? $clog2(BEATS_PER_BAR) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              pause,
  input  logic              stop,
  input  logic              period_load,
  input  logic [CNT_W-1:0]  period_in,
  output logic              tick,
  output logic              beat,
  output logic              bar,
  output logic [SUB_W-1:0]  sub_idx,
  output logic [BEAT_W-1:0] beat_idx,
  output logic [BAR_W-1:0]  bar_count,
  output logic              running
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_PAUSED = 2'd2;

`ifdef TEMPO_SWING_EN
  localparam logic [CNT_W-1:0] MIN_PERIOD = CNT_W'(4);
`else
  localparam logic [CNT_W-1:0] MIN_PERIOD = CNT_W'(2);
`endif
  localparam logic [CNT_W-1:0]  RST_PERIOD = CNT_W'(DEFAULT_PERIOD);
  localparam logic [SUB_W-1:0]  SUB_LAST   = SUB_W'(SUBDIV - 1);
  localparam logic [BEAT_W-1:0] BEAT_LAST  = BEAT_W'(BEATS_PER_BAR - 1);
  localparam logic [CNT_W:0]    T_ZERO     = {(CNT_W+1){1'b0}};
  localparam logic [CNT_W:0]    T_ONE      = {{CNT_W{1'b0}}, 1'b1};

  function automatic logic [CNT_W-1:0] clamp_period(input logic [CNT_W-1:0] p);
    logic [CNT_W-1:0] r;
    if (p < MIN_PERIOD) begin
      r = MIN_PERIOD;
    end else begin
      r = p;
    end
    return r;
  endfunction

  logic [1:0]        state_r, state_nxt_s;
  logic [CNT_W:0]    t_r, t_nxt_s;
  logic [CNT_W-1:0]  period_r, period_nxt_s;
  logic [CNT_W-1:0]  shadow_r, shadow_nxt_s;
  logic [SUB_W-1:0]  sub_idx_r, sub_nxt_s;
  logic [BEAT_W-1:0] beat_idx_r, beat_nxt_s;
  logic [BAR_W-1:0]  bar_count_r, barc_nxt_s;
  logic              tick_r, tick_nxt_s;
  logic              beat_r, beat_p_nxt_s;
  logic              bar_r, bar_p_nxt_s;
  logic              running_r, running_nxt_s;
  logic [CNT_W-1:0]  load_val_s;
  logic [CNT_W:0]    limit_s;
  logic              last_s;

  assign load_val_s = clamp_period(period_in);
  assign last_s     = (t_r == (limit_s - T_ONE));

  // Length of the tick interval currently being counted; t is one bit wider to hold the swung long interval.
  always_comb begin
`ifdef TEMPO_SWING_EN
    if (sub_idx_r[0]) begin
      limit_s = {1'b0, period_r} - {3'b000, period_r[CNT_W-1:2]};
    end else begin
      limit_s = {1'b0, period_r} + {3'b000, period_r[CNT_W-1:2]};
    end
`else
    limit_s = {1'b0, period_r};
`endif
  end

  // Next state, counters and pulse values for the grid controller.
  always_comb begin
    state_nxt_s  = state_r;
    t_nxt_s      = t_r;
    period_nxt_s = period_r;
    shadow_nxt_s = shadow_r;
    sub_nxt_s    = sub_idx_r;
    beat_nxt_s   = beat_idx_r;
    barc_nxt_s   = bar_count_r;
    tick_nxt_s   = 1'b0;
    beat_p_nxt_s = 1'b0;
    bar_p_nxt_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        t_nxt_s = T_ZERO;
        if (period_load) begin
          period_nxt_s = load_val_s;
          shadow_nxt_s = load_val_s;
        end else begin
          period_nxt_s = period_r;
          shadow_nxt_s = shadow_r;
        end
        if (start && !stop) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN, ST_PAUSED: begin
        if (period_load) begin
          shadow_nxt_s = load_val_s;
        end else begin
          shadow_nxt_s = shadow_r;
        end
        if (stop) begin
          // Abort: clear position and commit whatever period is pending.
          state_nxt_s  = ST_IDLE;
          t_nxt_s      = T_ZERO;
          sub_nxt_s    = {SUB_W{1'b0}};
          beat_nxt_s   = {BEAT_W{1'b0}};
          barc_nxt_s   = {BAR_W{1'b0}};
          period_nxt_s = shadow_nxt_s;
        end else if (state_r == ST_RUN) begin
          if (pause) begin
            state_nxt_s = ST_PAUSED;
          end else begin
            state_nxt_s = ST_RUN;
          end
          if (last_s) begin
            t_nxt_s      = T_ZERO;
            tick_nxt_s   = 1'b1;
            period_nxt_s = shadow_r;
            if (sub_idx_r == SUB_LAST) begin
              sub_nxt_s    = {SUB_W{1'b0}};
              beat_p_nxt_s = 1'b1;
              if (beat_idx_r == BEAT_LAST) begin
                beat_nxt_s  = {BEAT_W{1'b0}};
                bar_p_nxt_s = 1'b1;
                barc_nxt_s  = bar_count_r + BAR_W'(1);
              end else begin
                beat_nxt_s  = beat_idx_r + BEAT_W'(1);
              end
            end else begin
              sub_nxt_s = sub_idx_r + SUB_W'(1);
            end
          end else begin
            t_nxt_s = t_r + T_ONE;
          end
        end else begin
          if (pause) begin
            state_nxt_s = ST_PAUSED;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        t_nxt_s     = T_ZERO;
        sub_nxt_s   = {SUB_W{1'b0}};
        beat_nxt_s  = {BEAT_W{1'b0}};
        barc_nxt_s  = {BAR_W{1'b0}};
      end
    endcase
    running_nxt_s = (state_nxt_s != ST_IDLE);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      t_r         <= T_ZERO;
      period_r    <= RST_PERIOD;
      shadow_r    <= RST_PERIOD;
      sub_idx_r   <= {SUB_W{1'b0}};
      beat_idx_r  <= {BEAT_W{1'b0}};
      bar_count_r <= {BAR_W{1'b0}};
      tick_r      <= 1'b0;
      beat_r      <= 1'b0;
      bar_r       <= 1'b0;
      running_r   <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      t_r         <= t_nxt_s;
      period_r    <= period_nxt_s;
      shadow_r    <= shadow_nxt_s;
      sub_idx_r   <= sub_nxt_s;
      beat_idx_r  <= beat_nxt_s;
      bar_count_r <= barc_nxt_s;
      tick_r      <= tick_nxt_s;
      beat_r      <= beat_p_nxt_s;
      bar_r       <= bar_p_nxt_s;
      running_r   <= running_nxt_s;
    end
  end

  assign tick      = tick_r;
  assign beat      = beat_r;
  assign bar       = bar_r;
  assign sub_idx   = sub_idx_r;
  assign beat_idx  = beat_idx_r;
  assign bar_count = bar_count_r;
  assign running   = running_r;

endmodule

// File: tb/tb_beat_grid_gen.sv
// Bench for beat_grid_gen: constant vector table, directed corner sequences and random stimulus
// checked every cycle against a tick-count based reference model.
module tb_beat_grid_gen;
  localparam int CNT_W  = 25;
  localparam int DP     = 4;
  localparam int SUBDIV = 2;
  localparam int BPB    = 2;
  localparam int BAR_W  = 8;
  localparam int SUB_W  = (SUBDIV > 1) ? $clog2(SUBDIV) : 1;
  localparam int BEAT_W = (BPB > 1) ? $clog2(BPB) : 1;
`ifdef TEMPO_SWING_EN
  localparam int MINP  = 4;
  localparam bit SWING = 1'b1;
`else
  localparam int MINP  = 2;
  localparam bit SWING = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0, pause = 1'b0, stop = 1'b0, period_load = 1'b0;
  logic [CNT_W-1:0] period_in = '0;
  logic tick, beat, bar, running;
  logic [SUB_W-1:0]  sub_idx;
  logic [BEAT_W-1:0] beat_idx;
  logic [BAR_W-1:0]  bar_count;

  beat_grid_gen #(.CNT_W(CNT_W), .DEFAULT_PERIOD(DP), .SUBDIV(SUBDIV),
                  .BEATS_PER_BAR(BPB), .BAR_W(BAR_W)) dut (
    .clk(clk), .reset(reset), .start(start), .pause(pause), .stop(stop),
    .period_load(period_load), .period_in(period_in), .tick(tick), .beat(beat),
    .bar(bar), .sub_idx(sub_idx), .beat_idx(beat_idx), .bar_count(bar_count),
    .running(running));

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  // Reference model: 0 idle, 1 run, 2 paused; position derived from total ticks since start.
  int m_state, m_el, m_ticks, m_per, m_sh;
  bit e_tick, e_beat, e_bar;
  int cycle_no;
  int ticks_q[$];
  int beats_q[$];

  typedef struct {
    logic start; logic tick; logic beat; logic bar; int sub; int bidx; int barc;
  } vec_t;
  vec_t vec [17];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (time %0t)", name, got, exp, $time);
    end
  endtask

  function automatic int clampm(input int v);
    return (v < MINP) ? MINP : v;
  endfunction

  function automatic int ivl(input int p, input int n);
    if (!SWING) return p;
    else if (((n % SUBDIV) % 2) == 1) return p - p / 4;
    else return p + p / 4;
  endfunction

  function automatic int qget(input int q[$], input int i);
    if (i < q.size()) return q[i];
    else return -1;
  endfunction

  task automatic model_reset();
    m_state = 0; m_el = 0; m_ticks = 0; m_per = DP; m_sh = DP;
    e_tick = 1'b0; e_beat = 1'b0; e_bar = 1'b0;
  endtask

  task automatic model_step(input bit s, input bit p, input bit st, input bit ld, input int pin);
    int lv;
    lv = clampm(pin);
    e_tick = 1'b0; e_beat = 1'b0; e_bar = 1'b0;
    if (m_state == 0) begin
      if (ld) begin m_per = lv; m_sh = lv; end
      if (s && !st) begin m_state = 1; m_el = 0; end
    end else if (st) begin
      if (ld) m_sh = lv;
      m_per = m_sh; m_state = 0; m_el = 0; m_ticks = 0;
    end else if (m_state == 1) begin
      m_el++;
      if (m_el == ivl(m_per, m_ticks)) begin
        m_el = 0;
        m_ticks++;
        e_tick = 1'b1;
        e_beat = (m_ticks % SUBDIV) == 0;
        e_bar  = (m_ticks % (SUBDIV * BPB)) == 0;
        m_per  = m_sh;
      end
      if (ld) m_sh = lv;
      if (p) m_state = 2;
    end else begin
      if (ld) m_sh = lv;
      if (!p) m_state = 1;
    end
  endtask

  task automatic check_all();
    chk("tick", tick, e_tick);
    chk("beat", beat, e_beat);
    chk("bar", bar, e_bar);
    chk("sub_idx", sub_idx, m_ticks % SUBDIV);
    chk("beat_idx", beat_idx, (m_ticks / SUBDIV) % BPB);
    chk("bar_count", bar_count, (m_ticks / (SUBDIV * BPB)) % (1 << BAR_W));
    chk("running", running, m_state != 0);
  endtask

  task automatic cyc(input bit s, input bit p, input bit st, input bit ld, input int pin);
    @(negedge clk);
    start = s; pause = p; stop = st; period_load = ld; period_in = CNT_W'(pin);
    @(posedge clk);
    model_step(s, p, st, ld, pin);
    #1;
    cycle_no++;
    if (tick === 1'b1) ticks_q.push_back(cycle_no);
    if (beat === 1'b1) beats_q.push_back(cycle_no);
    check_all();
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic mark();
    cycle_no = -1;
    ticks_q.delete();
    beats_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; start = 1'b0; pause = 1'b0; stop = 1'b0; period_load = 1'b0; period_in = '0;
    model_reset();
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    bit pz;
    vec[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0};
    vec[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0};
    vec[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0};
    vec[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0};
    vec[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1, 0, 0};
    vec[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1, 0, 0};
    vec[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1, 0, 0};
    vec[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1, 0, 0};
    vec[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 0, 1, 0};
    vec[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 0, 1, 0};
    vec[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 0, 1, 0};
    vec[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 0, 1, 0};
    vec[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1, 1, 0};
    vec[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1, 1, 0};
    vec[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1, 1, 0};
    vec[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1, 1, 0};
    vec[16] = '{1'b0, 1'b1, 1'b1, 1'b1, 0, 0, 1};
    model_reset();
    cycle_no = 0;

    // Basic grid from start against the constant table.
    do_reset();
    mark();
`ifndef TEMPO_SWING_EN
    for (int i = 0; i < 17; i++) begin
      cyc(vec[i].start, 1'b0, 1'b0, 1'b0, 0);
      chk("s1_tick", tick, vec[i].tick);
      chk("s1_beat", beat, vec[i].beat);
      chk("s1_bar", bar, vec[i].bar);
      chk("s1_sub", sub_idx, vec[i].sub);
      chk("s1_bidx", beat_idx, vec[i].bidx);
      chk("s1_barc", bar_count, vec[i].barc);
      chk("s1_run", running, 1'b1);
    end
`endif

    // Pause from cycle 6 for 10 cycles; count resumes where it froze.
    do_reset();
    mark();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 0);
    idle(5);
    repeat (10) cyc(1'b0, 1'b1, 1'b0, 1'b0, 0);
    idle(6);
`ifndef TEMPO_SWING_EN
    chk("s2_nticks", ticks_q.size(), 2);
    chk("s2_tick0", qget(ticks_q, 0), 4);
    chk("s2_tick1", qget(ticks_q, 1), 18);
`endif

    // Period load while running applies at the next tick; load of 0 in idle clamps.
    do_reset();
    mark();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 0);
    idle(4);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 6);
    idle(15);
`ifndef TEMPO_SWING_EN
    chk("s3_nticks", ticks_q.size(), 4);
    chk("s3_tick1", qget(ticks_q, 1), 8);
    chk("s3_tick2", qget(ticks_q, 2), 14);
    chk("s3_tick3", qget(ticks_q, 3), 20);
`endif
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 0);
    mark();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 0);
    idle(4);
`ifndef TEMPO_SWING_EN
    chk("s3_p2_tick0", qget(ticks_q, 0), 2);
    chk("s3_p2_tick1", qget(ticks_q, 1), 4);
`endif

    // Stop mid-run clears position; restart; start with stop stays idle.
    do_reset();
    mark();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 0);
    idle(6);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 0);
    chk("s4_running", running, 1'b0);
    chk("s4_sub", sub_idx, 0);
    chk("s4_bidx", beat_idx, 0);
    idle(2);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 0);
    idle(4);
`ifndef TEMPO_SWING_EN
    chk("s4_restart_tick", qget(ticks_q, 1), 14);
`endif
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 0);
    chk("s4_start_stop_idle", running, 1'b0);

    // Asynchronous reset between edges while running with a changed period.
    do_reset();
    mark();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 0);
    idle(3);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 6);
    idle(6);
    #2;
    reset = 1'b1;
    #1;
    chk("s5_running", running, 1'b0);
    chk("s5_sub", sub_idx, 0);
    chk("s5_tick", tick, 1'b0);
    chk("s5_barc", bar_count, 0);
    model_reset();
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    reset = 1'b0;
    mark();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 0);
    idle(8);
`ifndef TEMPO_SWING_EN
    chk("s5_after_tick0", qget(ticks_q, 0), 4);
    chk("s5_after_tick1", qget(ticks_q, 1), 8);
`endif

`ifdef TEMPO_SWING_EN
    // Swing at period 8: long/short intervals 10 and 6.
    do_reset();
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 8);
    mark();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 0);
    idle(33);
    chk("s6_tick0", qget(ticks_q, 0), 10);
    chk("s6_tick1", qget(ticks_q, 1), 16);
    chk("s6_tick2", qget(ticks_q, 2), 26);
    chk("s6_tick3", qget(ticks_q, 3), 32);
    chk("s6_beat0", qget(beats_q, 0), 16);
    chk("s6_beat1", qget(beats_q, 1), 32);
`endif

    // Bar counter wrap at the minimum period.
    do_reset();
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 0);
    mark();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 0);
    idle(2060);
`ifndef TEMPO_SWING_EN
    chk("wrap_barc", bar_count, 1);
`endif

    // Random control traffic against the model.
    do_reset();
    mark();
    pz = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (($urandom % 12) == 0) pz = ~pz;
      cyc(($urandom % 10) == 0, pz, ($urandom % 50) == 0, ($urandom % 25) == 0,
          int'($urandom % 14));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
